// File: rtl/cpu_debug_slave_cmd_sync.sv
// rtl/cpu_debug_slave_cmd_sync.sv - clk-side debug command synchroniser, buffer and issuer
module cpu_debug_slave_cmd_sync #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int NUM_TARGETS = 1 << IR_WIDTH,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   vs_uir,
    input  logic                   vs_udr,
    input  logic [IR_WIDTH-1:0]    ir_in,
    input  logic [SR_WIDTH-1:0]    sr,
    input  logic                   cmd_ready,
    input  logic                   overflow_clr,
    output logic [SR_WIDTH-1:0]    jdo,
    output logic [IR_WIDTH-1:0]    cmd_ir,
    output logic [NUM_TARGETS-1:0] take_action,
    output logic [NUM_TARGETS-1:0] take_no_action,
    output logic [AW:0]            fifo_count,
    output logic                   overflow
);

    localparam int EW = IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
    logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
    logic                   uir_prev_q, uir_prev_d;
    logic                   udr_prev_q, udr_prev_d;
    logic                   uir_stb, udr_stb;

    logic [IR_WIDTH-1:0]    ir_q, ir_d;

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   fifo_empty, fifo_full;
    logic                   pop, push_ok, drop;
    logic [EW-1:0]          push_entry, head_entry;
    logic [IR_WIDTH-1:0]    head_ir;
    logic [SR_WIDTH-1:0]    head_data;

    logic [SR_WIDTH-1:0]    jdo_q, jdo_d;
    logic [IR_WIDTH-1:0]    cmd_ir_q, cmd_ir_d;
    logic [NUM_TARGETS-1:0] take_action_q, take_action_d;
    logic [NUM_TARGETS-1:0] take_no_action_q, take_no_action_d;
    logic                   overflow_q, overflow_d;

    // Synchroniser shift chains and single-cycle rising-edge strobes
    always_comb begin
        uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
        udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
        uir_prev_d = uir_sync_q[SYNC_STAGES-1];
        udr_prev_d = udr_sync_q[SYNC_STAGES-1];
        uir_stb    = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
        udr_stb    = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    end

    // FIFO status, push/pop decisions and next pointer values
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head_entry = mem_q[rd_ptr_q[AW-1:0]];
        head_ir    = head_entry[EW-1:SR_WIDTH];
        head_data  = head_entry[SR_WIDTH-1:0];
        pop        = ~fifo_empty & cmd_ready;
        // A same-cycle uir must win so the pushed command targets the new IR
        ir_d       = uir_stb ? ir_in : ir_q;
        push_entry = {ir_d, sr};
        push_ok    = udr_stb & (~fifo_full | pop);
        drop       = udr_stb & fifo_full & ~pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Issue stage: registered command data and one-hot per-target pulses
    always_comb begin
        jdo_d            = jdo_q;
        cmd_ir_d         = cmd_ir_q;
        take_action_d    = '0;
        take_no_action_d = '0;
        overflow_d       = overflow_q;
        if (pop) begin
            jdo_d                     = head_data;
            cmd_ir_d                  = head_ir;
            take_action_d[head_ir]    = head_data[SR_WIDTH-1];
            take_no_action_d[head_ir] = ~head_data[SR_WIDTH-1];
        end
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q       <= '0;
            udr_sync_q       <= '0;
            uir_prev_q       <= 1'b0;
            udr_prev_q       <= 1'b0;
            ir_q             <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            jdo_q            <= '0;
            cmd_ir_q         <= '0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            uir_sync_q       <= uir_sync_d;
            udr_sync_q       <= udr_sync_d;
            uir_prev_q       <= uir_prev_d;
            udr_prev_q       <= udr_prev_d;
            ir_q             <= ir_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            jdo_q            <= jdo_d;
            cmd_ir_q         <= cmd_ir_d;
            take_action_q    <= take_action_d;
            take_no_action_q <= take_no_action_d;
            overflow_q       <= overflow_d;
        end
    end

    // Command storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    assign jdo            = jdo_q;
    assign cmd_ir         = cmd_ir_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign fifo_count     = wr_ptr_q - rd_ptr_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_cpu_debug_slave_cmd_sync.sv
// tb/tb_cpu_debug_slave_cmd_sync.sv - self-checking bench for cpu_debug_slave_cmd_sync
module tb_cpu_debug_slave_cmd_sync;

    localparam int SR    = 38;
    localparam int IRW   = 2;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int NT    = 4;
    localparam int CW    = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            vs_uir, vs_udr;
    logic [IRW-1:0]  ir_in;
    logic [SR-1:0]   sr;
    logic            cmd_ready, overflow_clr;
    logic [SR-1:0]   jdo;
    logic [IRW-1:0]  cmd_ir;
    logic [NT-1:0]   take_action, take_no_action;
    logic [CW-1:0]   fifo_count;
    logic            overflow;

    cpu_debug_slave_cmd_sync #(
        .SR_WIDTH(SR), .IR_WIDTH(IRW), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
        .jdo(jdo), .cmd_ir(cmd_ir), .take_action(take_action),
        .take_no_action(take_no_action), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [IRW-1:0] ir;
        logic [SR-1:0]  data;
    } ent_t;

    ent_t           mq[$];
    logic [IRW-1:0] m_ir;
    logic [SR-1:0]  m_jdo;
    logic [IRW-1:0] m_cmd_ir;
    logic [NT-1:0]  m_ta, m_tna;
    logic           m_ovf;
    logic           udr_h [0:SYNC+1];
    logic           uir_h [0:SYNC+1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir = '0; m_jdo = '0; m_cmd_ir = '0; m_ta = '0; m_tna = '0; m_ovf = 1'b0;
        for (int k = 0; k <= SYNC + 1; k++) begin
            udr_h[k] = 1'b0;
            uir_h[k] = 1'b0;
        end
    endtask

    // A level seen SYNC edges ago that was low the edge before that is a strobe now
    task automatic model_edge();
        logic           udr_stb, uir_stb, drop;
        logic [IRW-1:0] push_ir;
        ent_t           e;
        udr_stb = udr_h[SYNC-1] && !udr_h[SYNC];
        uir_stb = uir_h[SYNC-1] && !uir_h[SYNC];
        push_ir = uir_stb ? ir_in : m_ir;
        if (uir_stb) m_ir = ir_in;
        m_ta = '0;
        m_tna = '0;
        drop = 1'b0;
        if (mq.size() > 0 && cmd_ready) begin
            e = mq.pop_front();
            m_jdo = e.data;
            m_cmd_ir = e.ir;
            if (e.data[SR-1]) m_ta[e.ir] = 1'b1;
            else              m_tna[e.ir] = 1'b1;
        end
        if (udr_stb) begin
            if (mq.size() < DEPTH) begin
                e.ir = push_ir;
                e.data = sr;
                mq.push_back(e);
            end else begin
                drop = 1'b1;
            end
        end
        if (overflow_clr) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        for (int k = SYNC + 1; k > 0; k--) begin
            udr_h[k] = udr_h[k-1];
            uir_h[k] = uir_h[k-1];
        end
        udr_h[0] = vs_udr;
        uir_h[0] = vs_uir;
    endtask

    task automatic check_model();
        chk("jdo", 64'(jdo), 64'(m_jdo));
        chk("cmd_ir", 64'(cmd_ir), 64'(m_cmd_ir));
        chk("take_action", 64'(take_action), 64'(m_ta));
        chk("take_no_action", 64'(take_no_action), 64'(m_tna));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic pulse_udr(input logic [SR-1:0] v);
        sr = v;
        vs_udr = 1'b1;
        step();
        vs_udr = 1'b0;
        step(); step(); step();
    endtask

    logic [SR-1:0] vals [0:4];
    logic [SR-1:0] xval;
    int            n;

    initial begin
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();
        #1;
        chk("reset_jdo", 64'(jdo), 64'd0);
        chk("reset_take_action", 64'(take_action), 64'd0);
        chk("reset_fifo_count", 64'(fifo_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step();

        // Defaults: action command to target 1, pulse three edges after udr is sampled
        ir_in = 2'b01; vs_uir = 1'b1;
        step(); step(); step();
        vs_uir = 1'b0;
        step(); step(); step();
        sr = 38'h20_0000_1234; cmd_ready = 1'b1; vs_udr = 1'b1;
        step(); step(); step();
        vs_udr = 1'b0;
        step();
        chk("t1_take_action", 64'(take_action), 64'h2);
        chk("t1_take_no_action", 64'(take_no_action), 64'h0);
        chk("t1_jdo", 64'(jdo), 64'h20_0000_1234);
        chk("t1_cmd_ir", 64'(cmd_ir), 64'd1);
        step();
        chk("t1_single_pulse", 64'(take_action), 64'h0);

        // No-action command to target 3
        ir_in = 2'd3; vs_uir = 1'b1;
        step(); step();
        vs_uir = 1'b0;
        step(); step();
        pulse_udr(38'h00_0000_0055);
        n = 0;
        while (take_no_action == '0 && n < 20) begin step(); n++; end
        chk("t2_wait", 64'(n < 20), 64'd1);
        chk("t2_take_no_action", 64'(take_no_action), 64'h8);
        chk("t2_take_action", 64'(take_action), 64'h0);
        step(); step();
        chk("t2_jdo_hold", 64'(jdo), 64'h00_0000_0055);

        // Overflow: five updates into a four-entry buffer with no consumer
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vals[i] = 38'h20_0000_0A00 + SR'(i);
            pulse_udr(vals[i]);
        end
        step(); step();
        chk("t3_count_full", 64'(fifo_count), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_order_jdo", 64'(jdo), 64'(vals[i]));
            chk("t3_order_pulse", 64'(take_action), 64'h8);
        end
        chk("t3_drained", 64'(fifo_count), 64'd0);
        step();
        chk("t3_no_fifth", 64'(take_action | take_no_action), 64'h0);

        // Full buffer with a same-cycle push and pop
        overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vals[i] = 38'h20_0000_0B00 + SR'(i);
            pulse_udr(vals[i]);
        end
        step();
        xval = 38'h20_0000_0BEE;
        sr = xval; vs_udr = 1'b1;
        step();
        vs_udr = 1'b0;
        step();
        cmd_ready = 1'b1;
        step();
        chk("t4_no_overflow", 64'(overflow), 64'd0);
        chk("t4_count_stays", 64'(fifo_count), 64'd4);
        chk("t4_first_pop", 64'(jdo), 64'(vals[0]));
        step(); step(); step(); step();
        chk("t4_new_last", 64'(jdo), 64'(xval));
        chk("t4_drained", 64'(fifo_count), 64'd0);

        // Clear coincident with a drop keeps the flag set
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse_udr(38'h20_0000_0C00 + SR'(i));
        sr = 38'h20_0000_0CFF; vs_udr = 1'b1;
        step();
        vs_udr = 1'b0;
        step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("t4_clr_vs_drop", 64'(overflow), 64'd1);
        overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
        chk("t4_clr", 64'(overflow), 64'd0);
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Coincident uir and udr: command must carry the new IR
        ir_in = 2'd2; sr = 38'h20_0000_0777; vs_uir = 1'b1; vs_udr = 1'b1;
        step(); step(); step();
        vs_uir = 1'b0; vs_udr = 1'b0;
        n = 0;
        while ((take_action | take_no_action) == '0 && n < 20) begin step(); n++; end
        chk("t5_wait", 64'(n < 20), 64'd1);
        chk("t5_cmd_ir", 64'(cmd_ir), 64'd2);
        chk("t5_take_action", 64'(take_action), 64'h4);

        // Mid-stream reset discards buffered commands
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse_udr(38'h20_0000_0D00 + SR'(i));
        step();
        chk("t6_buffered", 64'(fifo_count), 64'd3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_jdo", 64'(jdo), 64'd0);
        chk("t6_rst_cmd_ir", 64'(cmd_ir), 64'd0);
        chk("t6_rst_count", 64'(fifo_count), 64'd0);
        chk("t6_rst_pulses", 64'(take_action | take_no_action), 64'd0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_no_pulse", 64'(take_action | take_no_action), 64'd0);
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 7) == 0) vs_uir = ~vs_uir;
            if (!vs_uir) ir_in = IRW'($urandom);
            if (!vs_udr) sr = {6'($urandom), 32'($urandom)};
            step();
        end
        vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("final_drained", 64'(fifo_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_debug_slave_cmd_sync.md
Name: cpu_debug_slave_cmd_sync

Overview:
Parametrised system-clock side of the CPU debug slave. It takes the update-DR and update-IR strobes from the JTAG (tck) domain and synchronises them into clk. It captures each shifted command into a small FIFO and replays the commands to the CPU debug logic as one-cycle take_action / take_no_action pulses per target, with backpressure. Unlike the fixed 2-bit-IR, 38-bit, unbuffered predecessor, it scales in IR width, data width and sync depth, buffers back-to-back updates, and reports overflow.

Parameters:
SR_WIDTH, 38, width of the shifted data register and of jdo
IR_WIDTH, 2, virtual IR width; number of targets NUM_TARGETS = 2**IR_WIDTH
SYNC_STAGES, 2, flip-flop stages in each strobe synchroniser (legal range 2..4)
FIFO_DEPTH, 4, command buffer entries (power of 2, at least 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
vs_uir  in  1  update-IR level from the tck domain (asynchronous)
vs_udr  in  1  update-DR level from the tck domain (asynchronous)
ir_in  in  IR_WIDTH  virtual IR value; stable while vs_uir is high and until the next uir
sr  in  SR_WIDTH  shifted data; stable from vs_udr rise until the next shift
cmd_ready  in  1  CPU debug logic can accept a command this cycle
overflow_clr  in  1  clears the sticky overflow flag
jdo  out  SR_WIDTH  data of the command currently being issued (registered, held)
cmd_ir  out  IR_WIDTH  target index of the issued command (registered, held)
take_action  out  NUM_TARGETS  one-hot pulse: command with action bit = 1
take_no_action  out  NUM_TARGETS  one-hot pulse: command with action bit = 0
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky: a command was dropped

Behaviour:
- Reset (asynchronous, reset_n = 0) clears:
  - synchronisers and edge-detect registers
  - FIFO pointers
  - the captured IR register
  - outputs: jdo = 0, cmd_ir = 0, take_action = 0, take_no_action = 0, fifo_count = 0, overflow = 0
- A reset in mid-operation discards every buffered command. No pulse is issued after reset releases unless a new udr edge arrives.
- Synchronisers: vs_uir and vs_udr each pass through SYNC_STAGES flops. A rising-edge detect on the last stage produces a single-cycle uir_stb or udr_stb. A held level produces exactly one strobe.
- uir_stb: register ir_in into ir_q. ir_q is unchanged otherwise.
- udr_stb: push {ir_q, sr} into the FIFO at the next clk edge.
  - If uir_stb and udr_stb fire in the same cycle, the pushed IR is the new ir_in, not the old ir_q.
- Push while full with no pop in the same cycle: the entry is dropped, FIFO is unchanged, and overflow is set to 1.
  - Push while full with a pop in the same cycle succeeds; no overflow.
  - Push into an empty FIFO with a pop in the same cycle is not possible: an entry is poppable only the cycle after its push.
- overflow_clr clears overflow. If overflow_clr and a new drop happen in the same cycle, overflow stays 1.
- Issue: in any cycle with FIFO non-empty and cmd_ready = 1, pop the head and, at the next clock edge:
  - jdo <= head data; cmd_ir <= head IR
  - action bit = head data[SR_WIDTH-1]
  - take_action[cmd_ir] = action bit; take_no_action[cmd_ir] = ~action bit; all other bits 0
  - pulses last exactly one cycle
- At most one command is issued per cycle. With cmd_ready held at 1, back-to-back commands issue on consecutive cycles.
- cmd_ready = 0: no pop, no pulses. jdo and cmd_ir hold their last values.
- Latency: the first clk edge that samples vs_udr = 1 is edge 0. With FIFO empty and cmd_ready = 1, the pulse and the new jdo are visible after edge SYNC_STAGES+1.
- fifo_count updates at the same edge as push/pop: +1 for push only, -1 for pop only, unchanged for both or neither. It never exceeds FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. An extra MSB distinguishes full from empty.

Test Plan:
- Defaults. Set ir_in = 2'b01, pulse vs_uir for 3 cycles, then sr = 38'h20_0000_1234, pulse vs_udr for 3 cycles, cmd_ready = 1 -> take_action = 4'b0010 for exactly 1 cycle, 3 cycles after udr is first sampled; jdo = 38'h20_0000_1234, cmd_ir = 1; all other pulses 0.
- sr = 38'h00_0000_0055 with ir = 3 -> take_no_action = 4'b1000 and take_action = 0; jdo holds 38'h00_0000_0055 afterwards.
- cmd_ready = 0; five udr updates with distinct sr -> fifo_count reaches 4 and overflow = 1. Raise cmd_ready -> four pulses on consecutive cycles in push order, the fifth value is never issued, and fifo_count returns to 0.
- Full FIFO, a udr strobe and a pop in the same cycle -> no overflow, fifo_count stays 4, and the new entry issues last. Then overflow_clr=1 coincident with a drop -> overflow remains 1.
- uir and udr edges arrive together with ir_in = 2 -> the issued command has cmd_ir = 2.
- Buffer 3 commands, assert reset_n = 0 for 1 cycle mid-stream -> all outputs return to 0 immediately, fifo_count = 0, and no pulses follow the release.
